// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the multiplexed 7-segment scan driver:
//   active-low segment patterns {g,f,e,d,c,b,a}, the BCD converter FSM
//   state encoding, the digit index values used by the scanner, and a
//   helper that maps a BCD nibble to its segment pattern.
//   Optional feature macro used by the top level: LEADING_ZERO_BLANK_EN.

package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    localparam logic [1:0] DIG_ONES     = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;
    localparam logic [1:0] DIG_UNUSED   = 2'd3;

    // Non-decimal nibbles cannot occur after a valid conversion; they
    // are shown blank rather than as garbage.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble converter: 8-bit unsigned binary to three
//   BCD digits in 8 shift cycles plus one commit cycle.
//   Ports:
//     CLK      in   clock, rising edge
//     CLR      in   asynchronous active-high reset
//     DATA_IN  in   8-bit value to convert
//     LOAD     in   1-cycle start strobe; while busy it fills a 1-deep
//                   pending register (last strobe wins)
//     BUSY     out  high from the LOAD edge until the commit edge
//     H, T, O  out  hundreds / tens / ones digits, meaningful when VALID
//     VALID    out  high during the commit cycle; the consumer captures
//                   H/T/O on that clock edge

module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic [7:0] DATA_IN,
    input  logic       LOAD,
    output logic       BUSY,
    output logic [3:0] H,
    output logic [3:0] T,
    output logic [3:0] O,
    output logic       VALID
);

    conv_state_t state, state_next;

    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [11:0] bcd_adj;
    logic [2:0]  iter_q;
    logic [7:0]  pend_q;
    logic        pend_flag_q;
    logic        start;
    logic [7:0]  start_data;

    // State register.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and start decision. A strobe arriving on the commit
    // edge is folded into the pending path, so COMMIT restarts directly
    // from either the fresh DATA_IN or the stored pending value.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        start_data = LOAD ? DATA_IN : pend_q;
        case (state)
            ST_IDLE: begin
                if (LOAD) begin
                    start      = 1'b1;
                    state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                if (iter_q == 3'd7) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (LOAD || pend_flag_q) begin
                    start      = 1'b1;
                    state_next = ST_CONV;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < 3; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
            end
        end
    end

    // Datapath: capture on start, shift {bcd,bin} during CONV. Hundreds
    // never exceeds 2, so the bit shifted out of bcd_adj[11] is always 0.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
        end else if (start) begin
            bin_q  <= start_data;
            bcd_q  <= '0;
            iter_q <= '0;
        end else if (state == ST_CONV) begin
            bcd_q  <= {bcd_adj[10:0], bin_q[7]};
            bin_q  <= {bin_q[6:0], 1'b0};
            iter_q <= iter_q + 3'd1;
        end
    end

    // Pending register: only strobes seen mid-conversion land here;
    // strobes in IDLE or COMMIT start a conversion immediately.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
        end else if (state == ST_CONV && LOAD) begin
            pend_q      <= DATA_IN;
            pend_flag_q <= 1'b1;
        end else if (start) begin
            pend_flag_q <= 1'b0;
        end
    end

    assign BUSY  = (state != ST_IDLE);
    assign VALID = (state == ST_COMMIT);
    assign H     = bcd_q[11:8];
    assign T     = bcd_q[7:4];
    assign O     = bcd_q[3:0];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Drives a 4-digit multiplexed 7-segment display from an 8-bit value.
//   The value is converted to BCD by bin2bcd_seq; the digits are then
//   scanned one slot at a time, SCAN_DIV clocks per slot.
//   Parameters:
//     SCAN_DIV  clocks per digit slot (>= 2)
//   Ports:
//     CLK      in   clock, rising edge
//     CLR      in   asynchronous active-high reset
//     DATA_IN  in   8-bit unsigned value to display
//     LOAD     in   1-cycle strobe: capture DATA_IN and convert
//     BUSY     out  conversion in progress
//     ANODE    out  active-low one-hot digit enable, [0] = ones digit
//     SEG      out  active-low segments {g,f,e,d,c,b,a}
//   Build option:
//     LEADING_ZERO_BLANK_EN  blank leading zero hundreds/tens digits

module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 12500
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [7:0] DATA_IN,
    input  logic       LOAD,
    output logic       BUSY,
    output logic [3:0] ANODE,
    output logic [6:0] SEG
);

    localparam int               PRE_W   = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

    logic [3:0]       conv_h, conv_t, conv_o;
    logic             conv_valid;
    logic [3:0]       disp_h, disp_t, disp_o;
    logic [PRE_W-1:0] prescaler;
    logic [1:0]       digit_idx;
    logic [1:0]       idx_next;
    logic [3:0]       anode_next;
    logic [6:0]       seg_next;
    logic             blank_h, blank_t;

    bin2bcd_seq u_conv (
        .CLK     (CLK),
        .CLR     (CLR),
        .DATA_IN (DATA_IN),
        .LOAD    (LOAD),
        .BUSY    (BUSY),
        .H       (conv_h),
        .T       (conv_t),
        .O       (conv_o),
        .VALID   (conv_valid)
    );

    // Display registers change only on the commit cycle, so the previous
    // value stays on the display for the whole conversion.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            disp_h <= '0;
            disp_t <= '0;
            disp_o <= '0;
        end else if (conv_valid) begin
            disp_h <= conv_h;
            disp_t <= conv_t;
            disp_o <= conv_o;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_h = (disp_h == 4'd0);
    assign blank_t = (disp_h == 4'd0) && (disp_t == 4'd0);
`else
    assign blank_h = 1'b0;
    assign blank_t = 1'b0;
`endif

    // Outputs are built from the index the scanner is about to move to,
    // so ANODE/SEG and the index change on the same edge.
    always_comb begin
        idx_next   = digit_idx + 2'd1;
        anode_next = ~(4'b0001 << idx_next);
        seg_next   = SEG_BLANK;
        case (idx_next)
            DIG_ONES:     seg_next = seg_encode(disp_o);
            DIG_TENS:     seg_next = blank_t ? SEG_BLANK : seg_encode(disp_t);
            DIG_HUNDREDS: seg_next = blank_h ? SEG_BLANK : seg_encode(disp_h);
            default:      seg_next = SEG_BLANK;
        endcase
    end

    // Slot prescaler, scan index and registered display outputs.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            prescaler <= '0;
            digit_idx <= DIG_ONES;
            ANODE     <= 4'b1111;
            SEG       <= SEG_BLANK;
        end else if (prescaler == PRE_MAX) begin
            prescaler <= '0;
            digit_idx <= idx_next;
            ANODE     <= anode_next;
            SEG       <= seg_next;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

endmodule
